svm_dot_product: RTL and testbench

//  Downstream consumer of the deskew stage. After deskew writes the Q2.14 deskewed

---
 rtl/svm_pkg.sv | 26 ++
 rtl/svm_mac.sv | 99 +++++++++
 rtl/svm_dot_product.sv | 157 +++++++++++++++
 tb/tb_svm_dot_product.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// -----------------------------------------------------------------------------
// svm_pkg
// Shared constants and types for the SVM dot-product datapath.
//   IMG_SIZE / IMG_BASE : image geometry in the deskew BRAM
//   FRAC_BITS / FX_ONE  : Q2.14 fixed-point format of pixels and SV words
//   dot_state_t         : control FSM states of svm_dot_product
//   fx_t                : one signed Q2.14 word
// Optional build macro used by svm_mac: SVM_DOT_SAT_EN (saturating accumulate).
// -----------------------------------------------------------------------------
package svm_pkg;

    localparam int IMG_SIZE  = 784;
    localparam int IMG_BASE  = 784;
    localparam int FRAC_BITS = 14;
    localparam logic [15:0] FX_ONE = 16'h4000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dot_state_t;

    typedef logic signed [15:0] fx_t;

endpackage : svm_pkg

// File: rtl/svm_mac.sv
// -----------------------------------------------------------------------------
// svm_mac
// Two-stage signed multiply-accumulate: registered full-precision product,
// then sign-extended add into the accumulator.
// Build option: SVM_DOT_SAT_EN defined -> each add saturates to the ACC_WIDTH
// signed range and ovf latches on the first saturating add; otherwise the
// accumulator wraps modulo 2^ACC_WIDTH and ovf stays 0.
// Ports:
//   clk    in   clock
//   reset  in   async active-high reset (clears valid, acc, ovf)
//   clr    in   synchronous clear of acc and ovf at the start of a run
//   valid  in   a/b carry a valid pixel/SV pair this cycle
//   a, b   in   signed WIDTH operands
//   acc    out  signed ACC_WIDTH accumulator
//   ovf    out  sticky saturation flag
// -----------------------------------------------------------------------------
module svm_mac
    import svm_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        valid,
    input  logic signed [WIDTH-1:0]     a,
    input  logic signed [WIDTH-1:0]     b,
    output logic signed [ACC_WIDTH-1:0] acc,
    output logic                        ovf
);

    localparam int PROD_W = 2 * WIDTH;

    logic signed [PROD_W-1:0]    prod_p2_q;
    logic                        vld_p2_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        ovf_q;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]          add_res;

    // Returns {overflow_flag, next_acc}.
    function automatic logic [ACC_WIDTH:0] acc_add(
        input logic signed [ACC_WIDTH-1:0] x,
        input logic signed [ACC_WIDTH-1:0] y
    );
`ifdef SVM_DOT_SAT_EN
        logic [ACC_WIDTH:0] s;
        s = {x[ACC_WIDTH-1], x} + {y[ACC_WIDTH-1], y};
        // Top two bits disagree only when the true sum left the signed range.
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            if (s[ACC_WIDTH])
                acc_add = {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}};
            else
                acc_add = {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            acc_add = {1'b0, s[ACC_WIDTH-1:0]};
        end
`else
        acc_add = {1'b0, x + y};
`endif
    endfunction

    // Stage p2: product register (data only, gated by valid).
    always_ff @(posedge clk) begin
        if (valid)
            prod_p2_q <= a * b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_p2_q <= 1'b0;
        else
            vld_p2_q <= valid;
    end

    always_comb begin
        prod_ext = {{(ACC_WIDTH-PROD_W){prod_p2_q[PROD_W-1]}}, prod_p2_q};
        add_res  = acc_add(acc_q, prod_ext);
    end

    // Stage p3: accumulate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (vld_p2_q) begin
            acc_q <= add_res[ACC_WIDTH-1:0];
            ovf_q <= ovf_q | add_res[ACC_WIDTH];
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;

endmodule : svm_mac

// File: rtl/svm_dot_product.sv
// -----------------------------------------------------------------------------
// svm_dot_product
// Streams IMG_SIZE deskewed Q2.14 pixels from image BRAM together with one
// support vector from SV memory and accumulates their signed dot product
// (Q12.28). Control FSM: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
// Build option: SVM_DOT_SAT_EN (saturating accumulator, see svm_mac).
// Ports:
//   clk, reset        clock, async active-high reset
//   start, sv_index   launch a run (only while ready) using support vector sv_index
//   ready             idle / result valid
//   done              one-cycle completion pulse
//   dot, ovf          result and sticky overflow of the last run
//   img_address/en    image BRAM read port, img_in_data returns 1 cycle later
//   sv_address/en     SV memory read port, sv_in_data returns 1 cycle later
// -----------------------------------------------------------------------------
module svm_dot_product
    import svm_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int ADDR_WIDTH    = 11,
    parameter int IMG_SIZE      = svm_pkg::IMG_SIZE,
    parameter int IMG_BASE      = svm_pkg::IMG_BASE,
    parameter int SV_ADDR_WIDTH = 20,
    parameter int SV_IDX_WIDTH  = 10,
    parameter int ACC_WIDTH     = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [SV_IDX_WIDTH-1:0]  sv_index,
    output logic                     ready,
    output logic                     done,
    output logic [ACC_WIDTH-1:0]     dot,
    output logic                     ovf,
    output logic [ADDR_WIDTH-1:0]    img_address,
    input  logic [WIDTH-1:0]         img_in_data,
    output logic                     img_en,
    output logic [SV_ADDR_WIDTH-1:0] sv_address,
    input  logic [WIDTH-1:0]         sv_in_data,
    output logic                     sv_en
);

    localparam int CNT_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

    dot_state_t                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        en_q, en_d;
    logic [ADDR_WIDTH-1:0]       img_addr_q, img_addr_d;
    logic [SV_ADDR_WIDTH-1:0]    sv_addr_q, sv_addr_d;
    logic [SV_ADDR_WIDTH-1:0]    sv_base_q, sv_base_d;
    logic                        ready_q, ready_d;
    logic                        done_q, done_d;
    logic signed [ACC_WIDTH-1:0] dot_q, dot_d;
    logic                        vld_p1_q;
    logic                        clr;
    logic signed [ACC_WIDTH-1:0] mac_acc;
    logic                        mac_ovf;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        en_d       = 1'b0;
        img_addr_d = img_addr_q;
        sv_addr_d  = sv_addr_q;
        sv_base_d  = sv_base_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        dot_d      = dot_q;
        clr        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    cnt_d     = '0;
                    // Truncated to the SV address width; the caller keeps the index in range.
                    sv_base_d = SV_ADDR_WIDTH'(sv_index) * SV_ADDR_WIDTH'(IMG_SIZE);
                    ready_d   = 1'b0;
                    clr       = 1'b1;
                end
            end
            FETCH: begin
                en_d       = 1'b1;
                img_addr_d = ADDR_WIDTH'(IMG_BASE) + ADDR_WIDTH'(cnt_q);
                sv_addr_d  = sv_base_q + SV_ADDR_WIDTH'(cnt_q);
                if (cnt_q == CNT_W'(IMG_SIZE - 1))
                    state_d = DRAIN;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            DRAIN: begin
                // Once neither the address nor the data stage holds a pair, the
                // last product is being accumulated on this edge.
                if (!en_q && !vld_p1_q)
                    state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                ready_d = 1'b1;
                dot_d   = mac_acc;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: registered address/enable issue; stage p1: memory data valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            img_addr_q <= '0;
            sv_addr_q  <= '0;
            sv_base_q  <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            dot_q      <= '0;
            vld_p1_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            img_addr_q <= img_addr_d;
            sv_addr_q  <= sv_addr_d;
            sv_base_q  <= sv_base_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            dot_q      <= dot_d;
            vld_p1_q   <= en_q;
        end
    end

    svm_mac #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .valid (vld_p1_q),
        .a     (img_in_data),
        .b     (sv_in_data),
        .acc   (mac_acc),
        .ovf   (mac_ovf)
    );

    assign ready       = ready_q;
    assign done        = done_q;
    assign dot         = dot_q;
    assign ovf         = mac_ovf;
    assign img_address = img_addr_q;
    assign img_en      = en_q;
    assign sv_address  = sv_addr_q;
    assign sv_en       = en_q;

endmodule : svm_dot_product

// File: tb/tb_svm_dot_product.sv
module tb_svm_dot_product;

    localparam int N      = 784;
    localparam int BASE   = 784;
    localparam int LAT    = N + 4;
    localparam longint MAXV = 64'sd549755813887;   // 2^39-1
    localparam longint MINV = -64'sd549755813888;  // -2^39

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  sv_index = '0;
    logic        ready, done, ovf, img_en, sv_en;
    logic [39:0] dot;
    logic [10:0] img_address;
    logic [19:0] sv_address;
    logic [15:0] img_in_data, sv_in_data;

    logic [15:0] img_mem [0:2047];
    logic [15:0] sv_mem  [0:4095];

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    // Memory models with one-cycle registered read latency.
    always @(posedge clk) begin
        if (img_en) img_in_data <= img_mem[img_address];
        if (sv_en)  sv_in_data  <= sv_mem[sv_address[11:0]];
    end

    svm_dot_product dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .sv_index    (sv_index),
        .ready       (ready),
        .done        (done),
        .dot         (dot),
        .ovf         (ovf),
        .img_address (img_address),
        .img_in_data (img_in_data),
        .img_en      (img_en),
        .sv_address  (sv_address),
        .sv_in_data  (sv_in_data),
        .sv_en       (sv_en)
    );

    // Reference: plain sum of pairwise products over the image.
    function automatic logic [39:0] model_dot(input int idx, output bit ovf_m);
        longint acc = 0;
        longint p;
        ovf_m = 1'b0;
        for (int k = 0; k < N; k++) begin
            p = longint'($signed(img_mem[BASE + k])) * longint'($signed(sv_mem[idx * N + k]));
            acc = acc + p;
`ifdef SVM_DOT_SAT_EN
            if (acc > MAXV) begin acc = MAXV; ovf_m = 1'b1; end
            else if (acc < MINV) begin acc = MINV; ovf_m = 1'b1; end
`endif
        end
        return acc[39:0];
    endfunction

    task automatic fill(input int idx, input logic [15:0] iv, input logic [15:0] sv);
        for (int k = 0; k < N; k++) begin
            img_mem[BASE + k] = iv;
            sv_mem[idx * N + k] = sv;
        end
    endtask

    task automatic fill_random(input int idx, input int mode);
        for (int k = 0; k < N; k++) begin
            if (mode == 0) begin
                img_mem[BASE + k]   = 16'($urandom);
                sv_mem[idx * N + k] = 16'($urandom);
            end else begin
                img_mem[BASE + k]   = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
                sv_mem[idx * N + k] = 16'h8000;
            end
        end
    endtask

    // Launch a run and count edges until done (bounded).
    task automatic do_run(input int idx, output int cycles);
        @(negedge clk);
        start    = 1'b1;
        sv_index = 10'(idx);
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        while (cycles < 2000) begin
            @(posedge clk);
            #1 cycles++;
            if (done) break;
        end
    endtask

    task automatic test_reset;
        total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", ready); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
        total++; if (dot !== 40'h0) $display("FAIL reset_dot got %h exp 0", dot); else pass_cnt++;
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf); else pass_cnt++;
        total++; if ({img_en, sv_en} !== 2'b00) $display("FAIL reset_en got %b exp 00", {img_en, sv_en}); else pass_cnt++;
        total++; if (img_address !== 11'h0 || sv_address !== 20'h0)
            $display("FAIL reset_addr got %h/%h exp 0/0", img_address, sv_address); else pass_cnt++;
    endtask

    task automatic test_patterns;
        int cyc;
        bit om;
        logic [39:0] exp;
        // +1.0 * +1.0
        fill(0, 16'h4000, 16'h4000);
        do_run(0, cyc);
        total++; if (cyc !== LAT) $display("FAIL ones_latency got %0d exp %0d", cyc, LAT); else pass_cnt++;
        total++; if (dot !== 40'h31_0000_0000) $display("FAIL ones_dot got %h exp 3100000000", dot); else pass_cnt++;
        total++; if (ovf !== 1'b0) $display("FAIL ones_ovf got %b exp 0", ovf); else pass_cnt++;
        total++; if (ready !== 1'b1) $display("FAIL ones_ready got %b exp 1", ready); else pass_cnt++;
        // +1.0 * -1.0
        fill(0, 16'h4000, 16'hC000);
        do_run(0, cyc);
        total++; if (dot !== 40'hCF_0000_0000) $display("FAIL neg_dot got %h exp CF00000000", dot); else pass_cnt++;
        total++; if (ovf !== 1'b0) $display("FAIL neg_ovf got %b exp 0", ovf); else pass_cnt++;
        // Max positive -> overflow boundary
        fill(1, 16'h7FFF, 16'h7FFF);
        do_run(1, cyc);
`ifdef SVM_DOT_SAT_EN
        exp = 40'h7F_FFFF_FFFF;
        om  = 1'b1;
`else
        exp = 40'(64'd784 * 64'h3FFF_0001);
        om  = 1'b0;
`endif
        total++; if (dot !== exp) $display("FAIL max_dot got %h exp %h", dot, exp); else pass_cnt++;
        total++; if (ovf !== om) $display("FAIL max_ovf got %b exp %b", ovf, om); else pass_cnt++;
    endtask

    task automatic test_addressing;
        int n = 0;
        int addr_err = 0;
        int en_err = 0;
        int done_cnt = 0;
        int done_at = -1;
        fill(2, 16'h4000, 16'h2000);
        @(negedge clk);
        start    = 1'b1;
        sv_index = 10'd2;
        @(posedge clk);
        #1 start = 1'b0;
        for (n = 1; n <= LAT + 5; n++) begin
            @(posedge clk);
            #1;
            if (n <= N) begin
                if (!img_en || !sv_en) en_err++;
                if (img_address !== 11'(BASE + n - 1) || sv_address !== 20'(2 * N + n - 1)) addr_err++;
            end else if (img_en || sv_en) begin
                en_err++;
            end
            if (done) begin
                done_cnt++;
                done_at = n;
            end
        end
        total++; if (addr_err !== 0) $display("FAIL addr_seq got %0d bad cycles exp 0", addr_err); else pass_cnt++;
        total++; if (en_err !== 0) $display("FAIL en_window got %0d bad cycles exp 0", en_err); else pass_cnt++;
        total++; if (done_cnt !== 1) $display("FAIL done_count got %0d exp 1", done_cnt); else pass_cnt++;
        total++; if (done_at !== LAT) $display("FAIL done_cycle got %0d exp %0d", done_at, LAT); else pass_cnt++;
        total++; if (dot !== 40'h18_8000_0000) $display("FAIL idx2_dot got %h exp 1880000000", dot); else pass_cnt++;
    endtask

    task automatic test_restart_and_reset;
        int n;
        int cyc;
        int done_at = -1;
        fill(0, 16'h4000, 16'h4000);
        @(negedge clk);
        start    = 1'b1;
        sv_index = 10'd0;
        @(posedge clk);
        #1 start = 1'b0;
        for (n = 1; n <= LAT + 2; n++) begin
            if (n == 100) begin
                start    = 1'b1;
                sv_index = 10'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done && done_at < 0) done_at = n;
        end
        start = 1'b0;
        total++; if (done_at !== LAT) $display("FAIL ignore_start_cycle got %0d exp %0d", done_at, LAT); else pass_cnt++;
        total++; if (dot !== 40'h31_0000_0000) $display("FAIL ignore_start_dot got %h exp 3100000000", dot); else pass_cnt++;
        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (n = 1; n < 300; n++) begin
            @(posedge clk);
            #1;
        end
        #2 reset = 1'b1;
        #1;
        total++; if (ready !== 1'b1) $display("FAIL midreset_ready got %b exp 1", ready); else pass_cnt++;
        total++; if ({img_en, sv_en} !== 2'b00) $display("FAIL midreset_en got %b exp 00", {img_en, sv_en}); else pass_cnt++;
        total++; if (dot !== 40'h0) $display("FAIL midreset_dot got %h exp 0", dot); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        do_run(0, cyc);
        total++; if (cyc !== LAT) $display("FAIL after_reset_latency got %0d exp %0d", cyc, LAT); else pass_cnt++;
        total++; if (dot !== 40'h31_0000_0000) $display("FAIL after_reset_dot got %h exp 3100000000", dot); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int first_at = -1;
        int second_at = -1;
        logic [39:0] first_dot = '0;
        fill(0, 16'h4000, 16'hC000);
        @(negedge clk);
        start    = 1'b1;
        sv_index = 10'd0;
        while (n < 2 * LAT + 10 && second_at < 0) begin
            @(posedge clk);
            #1 n++;
            if (done) begin
                if (first_at < 0) begin
                    first_at  = n;
                    first_dot = dot;
                    // Second run fetches only after the restart edge; swap SV now.
                    fill(0, 16'h4000, 16'h4000);
                end else begin
                    second_at = n;
                    start     = 1'b0;
                end
            end
        end
        start = 1'b0;
        total++; if (first_dot !== 40'hCF_0000_0000) $display("FAIL b2b_first_dot got %h exp CF00000000", first_dot); else pass_cnt++;
        total++; if (second_at - first_at !== LAT + 1) $display("FAIL b2b_gap got %0d exp %0d", second_at - first_at, LAT + 1); else pass_cnt++;
        total++; if (dot !== 40'h31_0000_0000) $display("FAIL b2b_second_dot got %h exp 3100000000", dot); else pass_cnt++;
        total++; if (ovf !== 1'b0) $display("FAIL b2b_ovf got %b exp 0", ovf); else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        int cyc;
        int idx;
        bit om;
        logic [39:0] exp;
        for (int r = 0; r < 4; r++) begin
            idx = int'($urandom_range(0, 3));
            fill_random(idx, (r == 3) ? 1 : 0);
            exp = model_dot(idx, om);
            do_run(idx, cyc);
            total++; if (dot !== exp) $display("FAIL rand%0d_dot idx %0d got %h exp %h", r, idx, dot, exp); else pass_cnt++;
            total++; if (ovf !== om) $display("FAIL rand%0d_ovf got %b exp %b", r, ovf, om); else pass_cnt++;
            total++; if (cyc !== LAT) $display("FAIL rand%0d_latency got %0d exp %0d", r, cyc, LAT); else pass_cnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) img_mem[i] = '0;
        for (int i = 0; i < 4096; i++) sv_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_patterns;
        test_addressing;
        test_restart_and_reset;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule : tb_svm_dot_product
